// File: rtl/multi_switch_debouncer_if.sv
// Switch-bank interface: raw switch levels in, debounced levels and edge events out.
// master = the side that supplies raw levels and consumes events; slave = the debouncer.
interface multi_switch_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] q;          // raw, bouncy switch levels
  logic [CHANNELS-1:0] Q;          // debounced levels
  logic [CHANNELS-1:0] rise;       // one-cycle 0->1 event per channel
  logic [CHANNELS-1:0] fall;       // one-cycle 1->0 event per channel
  logic                any_event;  // OR of all rise/fall in the same cycle

  modport master (output q, input Q, rise, fall, any_event);
  modport slave  (input q, output Q, rise, fall, any_event);
endinterface

// File: rtl/multi_switch_debouncer.sv
// N-channel switch debouncer. Each channel runs a LO/WAIT_HI/HI/WAIT_LO FSM with a
// stability counter; a level change is accepted only after STABLE_CYCLES consecutive
// identical samples, and one-cycle rise/fall pulses coincide with the new Q value.
// Optional macro DEBOUNCER_SYNC_EN inserts a two-flop synchroniser per channel
// (q may then be asynchronous; latency grows by 2 cycles).
module multi_switch_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_switch_debouncer_if.slave   sw
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic [CHANNELS-1:0] s;          // sample seen by the FSMs
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic                any_q;

`ifdef DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] meta_q;
  logic [CHANNELS-1:0] sync_q;

  // Two-flop synchroniser in front of every channel
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sw.q;
      sync_q <= meta_q;
    end
  end

  assign s = sync_q;
`else
  assign s = sw.q;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_limit;
    logic          rise_c, fall_c, level_c;

    // Last sample of the acceptance window has been reached
    assign at_limit = (cnt_q == CW'(STABLE_CYCLES - 1));

    // State register: FSM state and stability counter
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state logic: any opposite sample during a WAIT state aborts the window
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        LO: begin
          if (s[gi]) begin
            state_d = WAIT_HI;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        WAIT_HI: begin
          if (!s[gi]) begin
            state_d = LO;
            cnt_d   = '0;
          end else if (at_limit) begin
            state_d = HI;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        HI: begin
          if (!s[gi]) begin
            state_d = WAIT_LO;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        WAIT_LO: begin
          if (s[gi]) begin
            state_d = HI;
            cnt_d   = '0;
          end else if (at_limit) begin
            state_d = LO;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: pulses and new level on the accepting transitions only
    always_comb begin
      rise_c  = 1'b0;
      fall_c  = 1'b0;
      level_c = level_q[gi];
      if (state_q == WAIT_HI && s[gi] && at_limit) begin
        rise_c  = 1'b1;
        level_c = 1'b1;
      end
      if (state_q == WAIT_LO && !s[gi] && at_limit) begin
        fall_c  = 1'b1;
        level_c = 1'b0;
      end
    end

    assign rise_d[gi]  = rise_c;
    assign fall_d[gi]  = fall_c;
    assign level_d[gi] = level_c;
  end

  // Registered outputs so Q and its pulse appear in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= |(rise_d | fall_d);
    end
  end

  assign sw.Q         = level_q;
  assign sw.rise      = rise_q;
  assign sw.fall      = fall_q;
  assign sw.any_event = any_q;

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// Scoreboard bench: the driver applies directed and random switch patterns, updates a
// run-length reference model at each posedge and queues the expected outputs; a monitor
// pops one entry per cycle on the falling edge and compares it with the DUT.
module tb_multi_switch_debouncer;

  localparam int CH = 4;
  localparam int N  = 10;
`ifdef DEBOUNCER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          ev;
  } exp_t;

  logic clk;
  logic reset;
  multi_switch_debouncer_if #(.CHANNELS(CH)) bus ();

  multi_switch_debouncer #(.CHANNELS(CH), .STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  // Reference model: a sample index since reset, and per channel the index of the
  // most recent sample that agreed with the accepted level (or of the last change).
  logic [CH-1:0] m_lvl;
  logic [CH-1:0] m_pipe0, m_pipe1;
  int            m_t;
  int            m_agree [CH];

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL cycle %0d %s: got %b expected %b", cycle, name, act, req);
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("Q",         bus.Q,                      e.lvl);
      check("rise",      bus.rise,                   e.rise);
      check("fall",      bus.fall,                   e.fall);
      check("any_event", {{(CH-1){1'b0}}, bus.any_event}, {{(CH-1){1'b0}}, e.ev});
      $display("cyc %0d rst=%b q=%b Q=%b rise=%b fall=%b ev=%b", cycle, reset, bus.q,
               bus.Q, bus.rise, bus.fall, bus.any_event);
    end
  end

  // Advance the model by one posedge and return the outputs expected after it
  function automatic exp_t model_step(input logic r, input logic [CH-1:0] qv);
    exp_t e;
    logic [CH-1:0] smp;
    e = '0;
    if (r) begin
      m_lvl   = '0;
      m_pipe0 = '0;
      m_pipe1 = '0;
      m_t     = 0;
      for (int i = 0; i < CH; i++) m_agree[i] = 0;
    end else begin
      smp     = SYNC ? m_pipe1 : qv;
      m_pipe1 = m_pipe0;
      m_pipe0 = qv;
      m_t++;
      for (int i = 0; i < CH; i++) begin
        if (smp[i] == m_lvl[i]) begin
          m_agree[i] = m_t;
        end else if (m_t - m_agree[i] == N) begin
          m_lvl[i]   = smp[i];
          e.rise[i]  = smp[i];
          e.fall[i]  = ~smp[i];
          m_agree[i] = m_t;
        end
      end
    end
    e.lvl = m_lvl;
    e.ev  = |(e.rise | e.fall);
    return e;
  endfunction

  task automatic step(input logic r, input logic [CH-1:0] qv);
    reset = r;
    bus.q = qv;
    @(posedge clk);
    sb.push_back(model_step(r, qv));
    @(negedge clk);
    cycle++;
  endtask

  task automatic hold(input logic r, input logic [CH-1:0] qv, input int n);
    for (int k = 0; k < n; k++) step(r, qv);
  endtask

  logic [CH-1:0] rq;
  int            left [CH];

  initial begin
    reset = 1'b1;
    bus.q = '0;
    m_lvl = '0; m_pipe0 = '0; m_pipe1 = '0; m_t = 0;
    for (int i = 0; i < CH; i++) m_agree[i] = 0;

    // Reset with all inputs high, then release: all channels rise together
    hold(1'b1, 4'hF, 2);
    hold(1'b0, 4'hF, 14);
    // Everything low again
    hold(1'b0, 4'h0, 14);
    // Bounce on channel 0, then a steady high
    step(1'b0, 4'h1); step(1'b0, 4'h0); step(1'b0, 4'h1);
    step(1'b0, 4'h1); step(1'b0, 4'h0);
    hold(1'b0, 4'h1, 14);
    // Short pulse on channel 1 (one sample too few)
    hold(1'b0, 4'h3, N - 1);
    hold(1'b0, 4'h1, 6);
    // Channel 2 up, then released
    hold(1'b0, 4'h5, 14);
    hold(1'b0, 4'h1, 14);
    // Setup for simultaneous events: channel 3 high, channel 0 low
    hold(1'b0, 4'h8, 14);
    // Channel 0 rises and channel 3 falls on the same cycle
    hold(1'b0, 4'h1, 14);
    // Same again, aborted by reset part-way through the window
    hold(1'b0, 4'h8, 14);
    hold(1'b0, 4'h1, 5);
    hold(1'b1, 4'h1, 1);
    hold(1'b0, 4'h0, 14);
    // Continuous toggling faster than the window never changes Q
    for (int k = 0; k < 30; k++) step(1'b0, (k % 8 < 4) ? 4'hF : 4'h0);

    // Randomised bouncing with occasional long holds and rare resets
    rq = '0;
    for (int i = 0; i < CH; i++) left[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) begin
        if (left[i] == 0) begin
          rq[i]   = ~rq[i];
          left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(N, 2 * N))
                                                 : int'($urandom_range(1, N - 1));
        end
        left[i]--;
      end
      step(($urandom_range(0, 499) == 0), rq);
    end
    hold(1'b0, 4'h0, 20);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
